// File: rtl/nios_system_onchip_ir_reader.sv
// Avalon-MM read master that streams a contiguous word range of the IR memory out as Avalon-ST.
// Latency: first st_valid two cycles after an accepted start; 1 word/cycle sustained after that.
// Backpressure: reads only issue when FIFO + in-flight has room, so a stalled sink never drops a word.
//
// Ports: clk/reset (async active-high); start/base_addr/length launch a transfer; busy/done status;
// mem_* is the Avalon-MM master to the 1-cycle-latency IR memory; st_* is the Avalon-ST source.
module nios_system_onchip_ir_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W:0]    iss_left_q, iss_left_d;  // reads still to issue
    logic [ADDR_W:0]    rem_q, rem_d;            // words still to hand to the sink
    logic               done_q, done_d;
    logic               inflight_q;              // read issued last cycle, data on mem_readdata now
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      wr_q, rd_q;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];

    logic               pop, push, room, start_ok, issue;
    logic [ADDR_W-1:0]  addr;
    logic [CW:0]        occ;

    assign pop      = (cnt_q != '0) && st_ready;
    assign push     = inflight_q;
    // Occupancy after this cycle's pop, counting the read landing now; a new read needs a free slot.
    assign occ      = {1'b0, cnt_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign room     = occ < DEPTH_V;
    // Gate with reset so the combinational issue path stays quiet while reset is held.
    assign start_ok = start & ~reset;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        iss_left_d = iss_left_q;
        rem_d      = pop ? rem_q - (ADDR_W+1)'(1) : rem_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        addr       = ptr_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First read goes out in the start cycle itself to hit the 2-cycle first-word latency.
                        issue      = 1'b1;
                        addr       = base_addr;
                        ptr_d      = base_addr + ADDR_W'(1);
                        iss_left_d = length - (ADDR_W+1)'(1);
                        rem_d      = length;
                        state_d    = (length == (ADDR_W+1)'(1)) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (room) begin
                    issue      = 1'b1;
                    ptr_d      = ptr_q + ADDR_W'(1);
                    iss_left_d = iss_left_q - (ADDR_W+1)'(1);
                    if (iss_left_q == (ADDR_W+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && rem_q == (ADDR_W+1)'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            iss_left_q <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            iss_left_q <= iss_left_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            inflight_q <= issue;
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_q] <= mem_readdata;
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign mem_address    = addr;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;
    assign st_valid       = (cnt_q != '0);
    assign st_data        = st_valid ? fifo_mem[rd_q] : '0;

endmodule

// File: tb/tb_nios_system_onchip_ir_reader.sv
module tb_nios_system_onchip_ir_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy, done;
    logic [9:0]  mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;

    nios_system_onchip_ir_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // IR memory model: memory[i] = i*3, one-cycle read latency.
    logic [31:0] mem_arr [1024];
    always @(posedge clk) if (mem_chipselect) mem_readdata <= mem_arr[mem_address];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Results of the latest transfer.
    int got[$];
    int first_lat, done_lat, done_cnt, cs_cnt, max_out, stab_err, busy_seen;

    // mode 0: st_ready=1; mode 1: toggle then hold 0 for 20 cycles; mode 2: ready=1 plus stray start at k=3.
    task automatic xfer(input int base, input int len, input int mode);
        int t0, outst, limit, rel;
        logic        hold_prev;
        logic [31:0] data_prev;
        got.delete();
        first_lat = -1; done_lat = -1; done_cnt = 0; cs_cnt = 0;
        max_out = 0; stab_err = 0; busy_seen = 0; outst = 0;
        hold_prev = 1'b0; data_prev = '0;
        limit = len + 60;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'(base); length = 11'(len); st_ready = 1'b1;
        t0 = cyc;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (hold_prev && st_data != data_prev) stab_err++;
            if (hold_prev && !st_valid) stab_err++;
            if (busy) busy_seen = 1;
            if (mem_chipselect) begin cs_cnt++; outst++; end
            if (st_valid && first_lat < 0) first_lat = cyc - t0;
            if (st_valid && st_ready) begin got.push_back(int'(st_data)); outst--; end
            if (outst > max_out) max_out = outst;
            hold_prev = st_valid && !st_ready;
            data_prev = st_data;
            if (done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = cyc - t0;
            end
            if (done_lat >= 0 && (cyc - t0) >= done_lat + 3) break;
            @(posedge clk); #1;
            start = 1'b0;
            rel = k + 1;
            if (mode == 1) begin
                if (rel < 8)       st_ready = (rel % 2 == 0);
                else if (rel < 28) st_ready = 1'b0;
                else               st_ready = 1'b1;
            end
            if (mode == 2 && k == 3) begin
                start = 1'b1; base_addr = 10'd700; length = 11'd5;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_seq(input string name, input int base, input int len);
        int bad = 0;
        check({name, "_count"}, got.size(), len);
        foreach (got[i]) if (got[i] != ((base + i) % 1024) * 3) bad++;
        check({name, "_order_errors"}, bad, 0);
    endtask

    typedef struct {
        int base;
        int len;
        int first;
        int last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{base: 5,    len: 8, first: 15,   last: 36};
        vecs[1] = '{base: 1022, len: 4, first: 3066, last: 3};
        vecs[2] = '{base: 0,    len: 1, first: 0,    last: 0};
        vecs[3] = '{base: 100,  len: 3, first: 300,  last: 306};
        vecs[4] = '{base: 1023, len: 2, first: 3069, last: 0};
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'(i * 3);

        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; st_ready = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_chipselect", mem_chipselect, 0);
        check("rst_address", mem_address, 0);
        check("rst_st_valid", st_valid, 0);
        check("rst_st_data", st_data, 0);
        check("const_write", mem_write, 0);
        check("const_byteenable", mem_byteenable, 15);
        check("const_clken", mem_clken, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven transfers with the sink always ready.
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            xfer(vecs[i].base, vecs[i].len, 0);
            check_seq(nm, vecs[i].base, vecs[i].len);
            check({nm, "_first"}, got.size() > 0 ? got[0] : -1, vecs[i].first);
            check({nm, "_last"}, got.size() > 0 ? got[got.size()-1] : -1, vecs[i].last);
            check({nm, "_first_valid_lat"}, first_lat, 2);
            check({nm, "_done_lat"}, done_lat, vecs[i].len + 2);
            check({nm, "_done_pulses"}, done_cnt, 1);
            check({nm, "_reads"}, cs_cnt, vecs[i].len);
        end

        // Zero length: done next cycle, no reads, busy never rises.
        xfer(77, 0, 0);
        check("len0_done_lat", done_lat, 1);
        check("len0_reads", cs_cnt, 0);
        check("len0_busy", busy_seen, 0);
        check("len0_words", got.size(), 0);

        // Backpressure: FIFO fills to depth and holds words stable.
        xfer(10, 16, 1);
        check_seq("bp", 10, 16);
        check("bp_max_buffered", max_out, 4);
        check("bp_stable", stab_err, 0);
        check("bp_done_pulses", done_cnt, 1);

        // Stray start while busy is ignored.
        xfer(40, 6, 2);
        check_seq("ign", 40, 6);
        check("ign_done_lat", done_lat, 8);
        check("ign_reads", cs_cnt, 6);
        check("ign_done_pulses", done_cnt, 1);

        // Full memory sweep.
        xfer(0, 1024, 0);
        check_seq("full", 0, 1024);
        check("full_done_lat", done_lat, 1026);
        check("full_done_pulses", done_cnt, 1);

        // Abort with reset after 3 words.
        begin
            int hs = 0, dn = 0, k = 0;
            @(posedge clk); #1;
            start = 1'b1; base_addr = 10'd200; length = 11'd10; st_ready = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            while (hs < 3 && k < 20) begin
                @(negedge clk);
                if (st_valid && st_ready) hs++;
                k++;
            end
            check("abort_reached_3_words", hs, 3);
            #1 reset = 1'b1;
            #1;
            check("abort_busy", busy, 0);
            check("abort_st_valid", st_valid, 0);
            check("abort_st_data", st_data, 0);
            check("abort_chipselect", mem_chipselect, 0);
            check("abort_address", mem_address, 0);
            repeat (3) begin @(negedge clk); if (done) dn++; end
            @(posedge clk); #1 reset = 1'b0;
            repeat (3) begin @(negedge clk); if (done || st_valid) dn++; end
            check("abort_no_done", dn, 0);
        end
        xfer(300, 3, 0);
        check_seq("after_abort", 300, 3);
        check("after_abort_done_lat", done_lat, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
